// File: rtl/music_pkg.sv
// Shared codes, FSM encoding and address helper for the song sequencer.
package music_pkg;

  localparam logic [1:0] SONG_NONE = 2'd0;
  localparam logic [1:0] SONG_1    = 2'd1;
  localparam logic [1:0] SONG_2    = 2'd2;
  localparam logic [1:0] SONG_3    = 2'd3;

  // ROM word layout: bit 7 flags end of song, all-zero is a rest
  localparam int unsigned END_MARK = 32'd7;
  localparam logic [7:0]  REST     = 8'd0;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_LOAD = 2'd2,
    ST_PLAY = 2'd3
  } state_t;

  // First ROM address of a song window; song 0 maps to 0 so it is harmless
  function automatic logic [7:0] song_base(input logic [1:0] song, input int unsigned song_len);
    logic [7:0] base;
    case (song)
      SONG_1:  base = 8'd0;
      SONG_2:  base = 8'(song_len);
      SONG_3:  base = 8'(32'd2 * song_len);
      default: base = 8'd0;
    endcase
    return base;
  endfunction

endpackage

// File: rtl/pad_sync_edge.sv
// Two-flop synchroniser for an asynchronous pad followed by a registered
// rising-edge pulse. The pulse is high for one clk, three clk after the pin rises.
module pad_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic pad,
  output logic rise
);

  // sync[0..1] resynchronise the pin, sync[2] holds the previous synchronised level
  logic [2:0] sync;

  // Shift the pin through the synchroniser and register the 0->1 transition
  always_ff @(posedge clk) begin
    if (reset) begin
      sync <= 3'b000;
      rise <= 1'b0;
    end else begin
      sync <= {sync[1:0], pad};
      rise <= sync[1] & ~sync[2];
    end
  end

endmodule

// File: rtl/song_sequencer.sv
// Player controller: arbitrates three song pads, walks the selected 64-entry
// ROM window one note per beat and drives the note and gate to the tone path.
module song_sequencer #(
  parameter int unsigned TICKS_PER_BEAT = 32'd4194304,
  parameter int unsigned GAP_TICKS      = 32'd262144,
  parameter int unsigned SONG_LEN       = 32'd64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       pad1,
  input  logic       pad2,
  input  logic       pad3,
  output logic [7:0] rom_addr,
  input  logic [7:0] rom_note,
  output logic [7:0] cur_note,
  output logic       note_gate,
  output logic       playing,
  output logic [1:0] song_id
);

  import music_pkg::*;

  localparam int unsigned BEAT_W = $clog2(TICKS_PER_BEAT);
  localparam int unsigned IDX_W  = $clog2(SONG_LEN);

  localparam logic [BEAT_W-1:0] BEAT_LAST = BEAT_W'(TICKS_PER_BEAT - 32'd1);
  localparam logic [BEAT_W:0]   GATE_END  = (BEAT_W + 1)'(TICKS_PER_BEAT - GAP_TICKS);
  localparam logic [IDX_W-1:0]  IDX_LAST  = IDX_W'(SONG_LEN - 32'd1);

  state_t            state;
  logic [1:0]        pending;
  logic [1:0]        req;
  logic [BEAT_W-1:0] beat_cnt;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  idx_next;
  logic              rise1;
  logic              rise2;
  logic              rise3;

  pad_sync_edge u_pad1 (.clk(clk), .reset(reset), .pad(pad1), .rise(rise1));
  pad_sync_edge u_pad2 (.clk(clk), .reset(reset), .pad(pad2), .rise(rise2));
  pad_sync_edge u_pad3 (.clk(clk), .reset(reset), .pad(pad3), .rise(rise3));

  // idx only ever wraps inside its own width, so the window base is never disturbed
  assign idx_next = idx + IDX_W'(1);

  // Silence during the articulation gap at the end of every slot and during rests
  assign note_gate = (state == ST_PLAY) && (cur_note != REST) && ({1'b0, beat_cnt} < GATE_END);

  // Fixed-priority pick among pads that fired this clk: lowest pad number wins
  always_comb begin
    req = SONG_NONE;
    if (rise1) begin
      req = SONG_1;
    end else if (rise2) begin
      req = SONG_2;
    end else if (rise3) begin
      req = SONG_3;
    end else begin
      req = SONG_NONE;
    end
  end

  // Sequencer FSM with pending-request register; a fresh pad edge overrides any clear of pending
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= ST_IDLE;
      pending  <= SONG_NONE;
      rom_addr <= 8'd0;
      cur_note <= 8'd0;
      playing  <= 1'b0;
      song_id  <= SONG_NONE;
      beat_cnt <= '0;
      idx      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (pending != SONG_NONE) begin
            song_id  <= pending;
            pending  <= SONG_NONE;
            rom_addr <= song_base(pending, SONG_LEN);
            idx      <= '0;
            playing  <= 1'b1;
            state    <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          state <= ST_LOAD;
        end
        ST_LOAD: begin
          if (rom_note[END_MARK]) begin
            state    <= ST_IDLE;
            playing  <= 1'b0;
            song_id  <= SONG_NONE;
            cur_note <= 8'd0;
          end else begin
            cur_note <= rom_note;
            beat_cnt <= '0;
            state    <= ST_PLAY;
          end
        end
        ST_PLAY: begin
          if (beat_cnt == BEAT_LAST) begin
            if (pending == song_id) begin
              // Same pad again stops the song
              pending  <= SONG_NONE;
              state    <= ST_IDLE;
              playing  <= 1'b0;
              song_id  <= SONG_NONE;
              cur_note <= 8'd0;
            end else if (pending != SONG_NONE) begin
              song_id  <= pending;
              pending  <= SONG_NONE;
              rom_addr <= song_base(pending, SONG_LEN);
              idx      <= '0;
              state    <= ST_ADDR;
            end else if (idx == IDX_LAST) begin
              // Window exhausted without an end marker
              state    <= ST_IDLE;
              playing  <= 1'b0;
              song_id  <= SONG_NONE;
              cur_note <= 8'd0;
            end else begin
              idx      <= idx_next;
              rom_addr <= song_base(song_id, SONG_LEN) + 8'(idx_next);
              state    <= ST_ADDR;
            end
          end else begin
            beat_cnt <= beat_cnt + BEAT_W'(1);
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
      if (req != SONG_NONE) begin
        pending <= req;
      end
    end
  end

endmodule

// File: tb/tb_song_sequencer.sv
// Bench for song_sequencer: directed table, hand-written corner sequences and
// randomized pad activity, all checked cycle by cycle against a slot-timeline model.
module tb_song_sequencer;

  localparam int T   = 16;
  localparam int G   = 2;
  localparam int LEN = 64;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pad1 = 1'b0;
  logic       pad2 = 1'b0;
  logic       pad3 = 1'b0;
  logic [7:0] rom_addr;
  logic [7:0] rom_note;
  logic [7:0] cur_note;
  logic       note_gate;
  logic       playing;
  logic [1:0] song_id;

  logic [7:0] rom [256];

  int n_vec  = 0;
  int n_miss = 0;
  bit check_en = 1'b0;
  int cyc = 0;

  // Reference model: song, position in window, and time within the note slot
  // (t=0 address cycle, t=1 load cycle, t=2..T+1 sounding beats 0..T-1)
  int         m_song;
  int         m_idx;
  int         m_t;
  int         m_pend;
  logic [7:0] m_note;
  logic [7:0] m_addr;
  logic [2:0] ph [4];

  always #5 clk = ~clk;

  song_sequencer #(.TICKS_PER_BEAT(T), .GAP_TICKS(G), .SONG_LEN(LEN)) dut (
    .clk(clk), .reset(reset), .pad1(pad1), .pad2(pad2), .pad3(pad3),
    .rom_addr(rom_addr), .rom_note(rom_note), .cur_note(cur_note),
    .note_gate(note_gate), .playing(playing), .song_id(song_id)
  );

  // Music ROM with one-cycle registered read
  always @(posedge clk) rom_note <= rom[rom_addr];

  task start_song(input int s);
    m_song = s;
    m_idx  = 0;
    m_addr = 8'((s - 1) * LEN);
    m_t    = 0;
  endtask

  task stop_song();
    m_song = 0;
    m_note = 8'd0;
  endtask

  // Advance the model by the clock edge that just happened
  task model_step();
    logic [2:0] req;
    int pick;
    if (reset) begin
      m_song = 0; m_idx = 0; m_t = 0; m_pend = 0;
      m_note = 8'd0; m_addr = 8'd0;
      for (int i = 0; i < 4; i++) ph[i] = 3'b000;
    end else begin
      // a pad registers as a request three edges after its pin rose
      req  = ph[2] & ~ph[3];
      pick = req[0] ? 1 : (req[1] ? 2 : (req[2] ? 3 : 0));
      ph[3] = ph[2]; ph[2] = ph[1]; ph[1] = ph[0]; ph[0] = {pad3, pad2, pad1};
      if (m_song == 0) begin
        if (m_pend != 0) begin
          start_song(m_pend);
          m_pend = 0;
        end
      end else if (m_t == 0) begin
        m_t = 1;
      end else if (m_t == 1) begin
        if (rom[m_addr][7]) stop_song();
        else begin
          m_note = rom[m_addr];
          m_t = 2;
        end
      end else if (m_t < T + 1) begin
        m_t++;
      end else begin
        if (m_pend == m_song) begin
          stop_song();
          m_pend = 0;
        end else if (m_pend != 0) begin
          start_song(m_pend);
          m_pend = 0;
        end else if (m_idx == LEN - 1) begin
          stop_song();
        end else begin
          m_idx++;
          m_addr = 8'((m_song - 1) * LEN + m_idx);
          m_t = 0;
        end
      end
      if (pick != 0) m_pend = pick;
    end
  endtask

  // Step the model and compare all outputs, half a cycle after each active edge
  always @(negedge clk) begin
    logic e_gate;
    logic e_play;
    cyc++;
    model_step();
    if (check_en) begin
      e_play = (m_song != 0);
      e_gate = (m_song != 0) && (m_t >= 2) && (m_note != 8'd0) && ((m_t - 2) < (T - G));
      n_vec++;
      if (song_id !== 2'(m_song) || rom_addr !== m_addr || cur_note !== m_note ||
          note_gate !== e_gate || playing !== e_play) begin
        n_miss++;
        $display("FAIL model cyc=%0d got song=%0d addr=%0d note=%0d gate=%0d play=%0d required song=%0d addr=%0d note=%0d gate=%0d play=%0d",
                 cyc, song_id, rom_addr, cur_note, note_gate, playing,
                 m_song, m_addr, m_note, e_gate, e_play);
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic expect_eq(input string name, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d, required %0d", name, got, exp);
    end
  endtask

  task automatic pulse(input logic [2:0] pads, input int hold);
    {pad3, pad2, pad1} = pads;
    tick(hold);
    {pad3, pad2, pad1} = 3'b000;
  endtask

  typedef struct {
    string      name;
    logic [2:0] pads;
    int         hold;
    int         cycles;
    int         exp_song;
    int         exp_addr;   // -1 = not checked
    int         exp_play;
  } vec_t;

  vec_t tbl [8];

  initial begin
    int bad, done, started, gcnt, prev_gate, r1, r2, maxa, mina, naddr, lasta;
    int q_addr [$];
    int q_note [$];

    for (int i = 0; i < 256; i++) rom[i] = 8'd0;
    for (int i = 2; i < 64; i++) rom[i] = 8'(12 + (i % 20));
    rom[0] = 8'd10;
    rom[1] = 8'd0;
    rom[64] = 8'd25; rom[65] = 8'd27; rom[66] = 8'h80;
    for (int i = 128; i < 192; i++) rom[i] = 8'(30 + (i % 24));

    tbl[0] = '{"idle",        3'b000, 0, 10, 0, 0,   0};
    tbl[1] = '{"pad1_pad3",   3'b101, 3,  6, 1, 0,   1};
    tbl[2] = '{"pad1_stop",   3'b001, 3, 30, 0, -1,  0};
    tbl[3] = '{"pad2_start",  3'b010, 3,  6, 2, 64,  1};
    tbl[4] = '{"song2_end",   3'b000, 0, 60, 0, -1,  0};
    tbl[5] = '{"pad3_start",  3'b100, 3,  6, 3, 128, 1};
    tbl[6] = '{"switch_to_2", 3'b010, 3, 30, 2, 64,  1};
    tbl[7] = '{"song2_end_b", 3'b000, 0, 60, 0, -1,  0};

    reset = 1'b1;
    tick(3);
    reset = 1'b0;
    check_en = 1'b1;

    // Idle for 100 clk after reset
    bad = 0;
    for (int c = 0; c < 100; c++) begin
      tick(1);
      if (playing !== 1'b0 || note_gate !== 1'b0 || rom_addr !== 8'd0) bad++;
    end
    expect_eq("idle_100", bad, 0);

    // Directed table
    for (int i = 0; i < 8; i++) begin
      pulse(tbl[i].pads, tbl[i].hold);
      tick(tbl[i].cycles - tbl[i].hold);
      expect_eq({tbl[i].name, "_song"}, int'(song_id), tbl[i].exp_song);
      if (tbl[i].exp_addr >= 0) expect_eq({tbl[i].name, "_addr"}, int'(rom_addr), tbl[i].exp_addr);
      expect_eq({tbl[i].name, "_play"}, int'(playing), tbl[i].exp_play);
    end

    // Song 2: addresses, notes, gate duty and note period
    pulse(3'b010, 3);
    started = 0; done = 0; gcnt = 0; prev_gate = 0; r1 = -1; r2 = -1;
    for (int c = 0; c < 200 && done == 0; c++) begin
      tick(1);
      if (playing) begin
        started = 1;
        if (q_addr.size() == 0 || q_addr[$] != int'(rom_addr)) q_addr.push_back(int'(rom_addr));
        if (cur_note != 8'd0 && (q_note.size() == 0 || q_note[$] != int'(cur_note))) q_note.push_back(int'(cur_note));
      end else if (started) done = 1;
      if (note_gate) gcnt++;
      if (note_gate && !prev_gate) begin
        if (r1 < 0) r1 = c; else if (r2 < 0) r2 = c;
      end
      prev_gate = int'(note_gate);
    end
    expect_eq("song2_done", done, 1);
    expect_eq("song2_naddr", q_addr.size(), 3);
    expect_eq("song2_addr0", q_addr.size() > 0 ? q_addr[0] : -1, 64);
    expect_eq("song2_addr1", q_addr.size() > 1 ? q_addr[1] : -1, 65);
    expect_eq("song2_addr2", q_addr.size() > 2 ? q_addr[2] : -1, 66);
    expect_eq("song2_note0", q_note.size() > 0 ? q_note[0] : -1, 25);
    expect_eq("song2_note1", q_note.size() > 1 ? q_note[1] : -1, 27);
    expect_eq("song2_gate_cycles", gcnt, 2 * (T - G));
    expect_eq("song2_note_period", r2 - r1, T + 2);

    // Song 1 with a rest at idx 1, then switch to song 3 mid-slot
    pulse(3'b001, 3);
    done = 0; bad = 0; gcnt = 0;
    for (int c = 0; c < 100 && done == 0; c++) begin
      tick(1);
      if (playing && rom_addr == 8'd1 && note_gate) bad++;
      if (playing && rom_addr == 8'd0 && note_gate) gcnt++;
      if (playing && rom_addr == 8'd2) done = 1;
    end
    expect_eq("rest_silent", bad, 0);
    expect_eq("note0_gate", gcnt, T - G);
    expect_eq("rest_continues", done, 1);
    pulse(3'b100, 3);
    done = 0;
    for (int c = 0; c < 60 && done == 0; c++) begin
      tick(1);
      if (song_id == 2'd3) done = 1;
    end
    expect_eq("switch_seen", done, 1);
    expect_eq("switch_addr", int'(rom_addr), 128);

    // Song 3 window has no end marker: all 64 entries then stop
    done = 0; maxa = 0; mina = 255; naddr = 0; lasta = -1;
    for (int c = 0; c < 1300 && done == 0; c++) begin
      if (playing) begin
        if (int'(rom_addr) > maxa) maxa = int'(rom_addr);
        if (int'(rom_addr) < mina) mina = int'(rom_addr);
        if (int'(rom_addr) != lasta) naddr++;
        lasta = int'(rom_addr);
      end else done = 1;
      if (done == 0) tick(1);
    end
    expect_eq("song3_stopped", done, 1);
    expect_eq("song3_max_addr", maxa, 191);
    expect_eq("song3_min_addr", mina, 128);
    expect_eq("song3_naddr", naddr, 64);

    // Same pad again stops at the slot end
    pulse(3'b001, 3);
    tick(10);
    pulse(3'b001, 3);
    done = 0;
    for (int c = 0; c < 40 && done == 0; c++) begin
      tick(1);
      if (!playing) done = 1;
    end
    expect_eq("repress_stop", done, 1);
    expect_eq("repress_song", int'(song_id), 0);

    // Reset while playing with a request still pending
    pulse(3'b010, 3);
    tick(12);
    pulse(3'b100, 3);
    tick(2);
    reset = 1'b1;
    tick(1);
    expect_eq("rst_play", int'(playing), 0);
    expect_eq("rst_gate", int'(note_gate), 0);
    expect_eq("rst_song", int'(song_id), 0);
    expect_eq("rst_addr", int'(rom_addr), 0);
    expect_eq("rst_note", int'(cur_note), 0);
    reset = 1'b0;
    tick(30);
    expect_eq("rst_pending_dropped", int'(playing), 0);

    // Random ROM contents and random pad activity with occasional resets
    reset = 1'b1;
    for (int i = 0; i < 256; i++) begin
      int r;
      r = $urandom_range(0, 99);
      rom[i] = (r < 3) ? 8'h80 : ((r < 13) ? 8'd0 : 8'($urandom_range(1, 63)));
    end
    tick(2);
    reset = 1'b0;
    for (int c = 0; c < 6000; c++) begin
      int r;
      r = $urandom_range(0, 999);
      if (r < 40) {pad3, pad2, pad1} = 3'($urandom_range(0, 7));
      else if (r < 100) {pad3, pad2, pad1} = 3'b000;
      reset = (r == 999);
      tick(1);
    end
    reset = 1'b0;
    tick(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
